// File: rtl/data_modulate_pkg.sv
// data_modulate_pkg: shared constants, FSM encoding and width helper for the data-modulate sequencers
package data_modulate_pkg;
  localparam int K9 = 9;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/data_modulate_rc_counter.sv
// data_modulate_rc_counter: column/window-row counters with clear, increment and wrap flags
module data_modulate_rc_counter #(
  parameter int COLS = 11,
  parameter int OUT_ROWS = 3,
  parameter int K = 9,
  parameter int CW = 4,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] c,
  output logic [RW-1:0] r,
  output logic          c_last,
  output logic          r_last,
  output logic          c_ge_k1
);
  assign c_last  = c == CW'(COLS - 1);
  assign r_last  = r == RW'(OUT_ROWS - 1);
  assign c_ge_k1 = c >= CW'(K - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
      r <= '0;
    end else if (clr) begin
      c <= '0;
      r <= '0;
    end else if (inc) begin
      c <= c_last ? '0 : c + 1'b1;
      r <= c_last ? (r_last ? '0 : r + 1'b1) : r;
    end
  end
endmodule

// File: rtl/data_modulate_9x9_sequencer.sv
// data_modulate_9x9_sequencer: frame controller gating the 9x9 window datapath and tagging window coordinates
module data_modulate_9x9_sequencer
  import data_modulate_pkg::*;
#(
  parameter int ROWS = 11,
  parameter int COLS = 11,
  parameter int K = K9,
  localparam int RW = clog2w(ROWS),
  localparam int CW = clog2w(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          valid_i,
  input  logic          done_i,
  output logic          ready_o,
  output logic          shift_en_o,
  output logic          window_valid_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  localparam int OUT_ROWS = ROWS - K + 1;
  if (ROWS < K) begin : g_bad_rows
    $error("ROWS must be >= K");
  end
  if (COLS < K) begin : g_bad_cols
    $error("COLS must be >= K");
  end
  state_t state;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic c_last, r_last, c_ge_k1, accept, final_acc, abort, win;
  assign ready_o    = state == ST_LOAD || state == ST_RUN;
  assign busy_o     = state != ST_IDLE;
  assign accept     = valid_i & ready_o;
  assign shift_en_o = accept;
  assign final_acc  = accept & (state == ST_RUN) & c_last & r_last;
  // an early done_i aborts, unless it lands on the very last column
  assign abort      = ready_o & done_i & ~final_acc;
  assign win        = accept & c_ge_k1;
  data_modulate_rc_counter #(
    .COLS(COLS), .OUT_ROWS(OUT_ROWS), .K(K), .CW(CW), .RW(RW)
  ) u_rc (
    .clk(clk), .rst(rst),
    .clr((state == ST_IDLE && start_i) || abort),
    .inc(accept),
    .c(c), .r(r), .c_last(c_last), .r_last(r_last), .c_ge_k1(c_ge_k1)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      window_valid_o <= 1'b0;
      row_o          <= '0;
      col_o          <= '0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      window_valid_o <= win;
      if (win) begin
        row_o <= r;
        col_o <= c - CW'(K - 1);
      end
      done_o <= 1'b0;
      unique case (state)
        ST_IDLE:  if (start_i) begin
                    state <= ST_LOAD;
                    err_o <= 1'b0;
                  end
        ST_LOAD:  if (abort) begin
                    state  <= ST_DONE;
                    err_o  <= 1'b1;
                    done_o <= 1'b1;
                  end else if (accept && c == CW'(K - 2)) state <= ST_RUN;
        ST_RUN:   if (abort) begin
                    state  <= ST_DONE;
                    err_o  <= 1'b1;
                    done_o <= 1'b1;
                  end else if (final_acc) state <= ST_DRAIN;
                  else if (accept && c_last) state <= ST_LOAD;
        ST_DRAIN: begin
                    state  <= ST_DONE;
                    done_o <= 1'b1;
                  end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule
